fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00000000, PC loaded on reset.
REQ-002 SHALL have port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: nRST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: ifid_en  input  1  IF/ID latch enable from hazard unit; 0 = stall.
REQ-005 SHALL have port: ifid_sRST  input  1  IF/ID synchronous bubble insert from hazard unit.
REQ-006 SHALL have port: redirect  input  1  taken branch/jump resolved downstream.
REQ-007 SHALL have port: redirect_addr  input  32  redirect target.
REQ-008 SHALL have port: halt  input  1  halt reached memory stage.
REQ-009 SHALL have port: ihit  input  1  instruction memory returns data this cycle.
REQ-010 SHALL have port: iload  input  32  instruction word, valid when ihit=1.
REQ-011 SHALL have port: imemREN  output  1  instruction read request.
REQ-012 SHALL have port: imemaddr  output  32  word-aligned fetch address.
REQ-013 SHALL have port: instr_id  output  32  IF/ID instruction.
REQ-014 SHALL have port: pcplus4_id  output  32  IF/ID PC+4 of instr_id.
REQ-015 SHALL have port: valid_id  output  1  IF/ID holds a real instruction.
REQ-016 SHALL have port: halted  output  1  fetch permanently stopped.

Function
REQ-017 SHALL implement states FETCH, SKID, HALT; SKID reachable only with FETCH_SKID_EN.
REQ-018 SHALL drive imemaddr = {pc[31:2],2'b00}; redirect_addr[1:0] ignored.
REQ-019 SHALL assert imemREN=1 in FETCH, 0 in SKID and HALT.
REQ-020 SHALL, in FETCH with ihit=1, ifid_en=1, no redirect: load instr_id<=iload, pcplus4_id<=pc+4, valid_id<=1, pc<=pc+4 (one-cycle latency, ihit to IF/ID).
REQ-021 SHALL compute pc+4 modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-022 SHALL, when ifid_en=0, hold instr_id, pcplus4_id, valid_id unchanged.
REQ-023 SHALL, when ifid_sRST=1, clear instr_id to 0 and valid_id to 0 regardless of ifid_en; pcplus4_id holds.
REQ-024 SHALL, on redirect=1, set pc<=redirect_addr aligned, discard any same-cycle ihit, empty the skid entry, return to FETCH from SKID.
REQ-025 SHALL give priority: nRST > halt > redirect > ifid_sRST > sequential fetch.
REQ-026 SHALL, on halt=1, enter HALT next cycle; halted=1, imemREN=0, pc frozen until reset.
REQ-027 SHALL ignore redirect, ihit and ifid_en in HALT; IF/ID still obeys ifid_sRST.

Reset
REQ-028 SHALL, on nRST=1 at a clock edge, set pc=RESET_PC, state=FETCH, instr_id=0, pcplus4_id=0, valid_id=0, halted=0, skid empty.
REQ-029 SHALL discard any in-flight ihit on the reset cycle; imemREN=1 on the first cycle after reset.

Configuration
REQ-030 SHALL, with FETCH_SKID_EN defined, on ihit=1 and ifid_en=0 in FETCH: capture iload and pc+4 into a one-entry skid buffer, pc<=pc+4, enter SKID.
REQ-031 SHALL, in SKID with ifid_en=1: move skid to IF/ID (valid_id=1), empty skid, return to FETCH.
REQ-032 SHALL, with FETCH_SKID_EN undefined, ignore ihit when ifid_en=0: pc holds, imemREN stays 1, same address re-fetched.

Verification
REQ-033 SHALL cover: reset, 3 ihit cycles with ifid_en=1 -> imemaddr 0,4,8,C; pcplus4_id 4,8,C.
REQ-034 SHALL cover: pc=0x40, redirect=1 addr=0x103 with ihit=1 -> next imemaddr=0x100, IF/ID not loaded from dropped ihit.
REQ-035 SHALL cover: pc=0xFFFFFFFC, ihit, ifid_en=1 -> pcplus4_id=0, imemaddr=0.
REQ-036 SHALL cover: ihit with ifid_en=0 for 2 cycles then 1 -> with FETCH_SKID_EN imemREN=0 during stall, skid word delivered once; without, same address re-fetched, no duplicate.
REQ-037 SHALL cover: halt=1 with redirect=1 same cycle -> HALT, halted=1, imemREN=0, pc unchanged; nRST=1 then restores pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC register and IF/ID latch
//
// Ports:
//   CLK            sole clock, rising edge
//   nRST           synchronous active-high reset
//   ifid_en        IF/ID latch enable (0 = stall)
//   ifid_sRST      IF/ID bubble insert
//   redirect       taken branch/jump, target in redirect_addr
//   redirect_addr  redirect target (low two bits ignored)
//   halt           halt reached memory stage
//   ihit / iload   instruction memory response
//   imemREN        instruction read request
//   imemaddr       word-aligned fetch address
//   instr_id       IF/ID instruction
//   pcplus4_id     IF/ID PC+4 of instr_id
//   valid_id       IF/ID holds a real instruction
//   halted         fetch permanently stopped until reset
//
// Optional feature: define FETCH_SKID_EN to add a one-entry skid buffer that
// keeps a word returned during a stall instead of re-fetching it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ifid_en,
    input  logic        ifid_sRST,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_id,
    output logic [31:0] pcplus4_id,
    output logic        valid_id,
    output logic        halted
);
    typedef enum logic [1:0] {FETCH, SKID, HALT} state_t;
    state_t state;
    logic [31:0] pc;
    logic [31:0] pc4;
`ifdef FETCH_SKID_EN
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
`endif
    assign pc4      = pc + 32'd4;
    assign imemaddr = {pc[31:2], 2'b00};
    assign imemREN  = state == FETCH;
    assign halted   = state == HALT;
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            instr_id   <= '0;
            pcplus4_id <= '0;
            valid_id   <= 1'b0;
        end else if (state == HALT || halt) begin
            state <= HALT;
            if (ifid_sRST) begin
                instr_id <= '0;
                valid_id <= 1'b0;
            end
        end else if (redirect) begin
            // the same-cycle ihit is dropped, so an open latch takes a bubble
            state <= FETCH;
            pc    <= {redirect_addr[31:2], 2'b00};
            if (ifid_sRST || ifid_en) begin
                instr_id <= '0;
                valid_id <= 1'b0;
            end
        end else if (ifid_sRST) begin
            instr_id <= '0;
            valid_id <= 1'b0;
        end else if (state == SKID) begin
`ifdef FETCH_SKID_EN
            if (ifid_en) begin
                state      <= FETCH;
                instr_id   <= skid_instr;
                pcplus4_id <= skid_pc4;
                valid_id   <= 1'b1;
            end
`endif
        end else if (ifid_en) begin
            // no returned word means the open latch takes a bubble
            instr_id <= ihit ? iload : 32'd0;
            valid_id <= ihit;
            if (ihit) begin
                pcplus4_id <= pc4;
                pc         <= pc4;
            end
        end
`ifdef FETCH_SKID_EN
        else if (ihit) begin
            state      <= SKID;
            skid_instr <= iload;
            skid_pc4   <= pc4;
            pc         <= pc4;
        end
`endif
    end
endmodule
